// File: rtl/count_data_path.sv
`default_nettype none
// ============================================================================
// Module   : count_data_path
// Purpose  : Datapath stage under the counter control FSM. Holds the
//            sub-counter s, the main counter y, a capture register for the
//            external preset x, and the sticky overflow flag. It executes the
//            FSM command strobes every clock and returns the branch flags.
// Ports    : clk, rst (async, active-high)
//            x_in / x_load                       - preset capture
//            y_en, y_store_x, y_select_next      - y commands
//            s_en, s_zero, s_add, s_step         - s commands
//            y, s, y_ovf                         - registered state
//            y_inc, s_empty                      - combinational flags
// Revision : 1.0 - initial release
// ============================================================================
module count_data_path #(
    parameter int YW     = 8,
    parameter int SW     = 4,
    parameter int S_MOD  = 4,
    parameter int S_LOAD = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [YW-1:0] x_in,
    input  logic          x_load,
    input  logic [1:0]    y_select_next,
    input  logic [1:0]    s_step,
    input  logic          y_en,
    input  logic          s_en,
    input  logic          y_store_x,
    input  logic          s_add,
    input  logic          s_zero,
    output logic [YW-1:0] y,
    output logic [SW-1:0] s,
    output logic          y_inc,
    output logic          s_empty,
    output logic          y_ovf
);

    localparam logic [1:0]    Y_SEL_HOLD = 2'd0;
    localparam logic [1:0]    Y_SEL_INC  = 2'd1;
    localparam logic [1:0]    Y_SEL_DEC  = 2'd2;
    localparam logic [1:0]    Y_SEL_CLR  = 2'd3;

    localparam logic [SW:0]   S_MOD_W    = (SW+1)'(S_MOD);
    localparam logic [SW-1:0] S_LAST     = SW'(S_MOD - 1);
    localparam logic [SW-1:0] S_LOAD_W   = SW'(S_LOAD);
    localparam logic [YW-1:0] Y_ONES     = {YW{1'b1}};

    logic [YW-1:0] x_reg_q, x_reg_d;
    logic [YW-1:0] y_q, y_d;
    logic [SW-1:0] s_q, s_d;
    logic          y_ovf_q, y_ovf_d;

    logic [YW-1:0] x_eff;
    logic [SW-1:0] s_base;
    logic [SW:0]   s_sum;
    logic [SW:0]   s_step_w;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_reg_q <= '0;
            y_q     <= '0;
            s_q     <= '0;
            y_ovf_q <= 1'b0;
        end else begin
            x_reg_q <= x_reg_d;
            y_q     <= y_d;
            s_q     <= s_d;
            y_ovf_q <= y_ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Preset capture; the bypass lets a same-cycle load+store use x_in.
    // ------------------------------------------------------------------
    always_comb begin
        x_reg_d = x_load ? x_in : x_reg_q;
        x_eff   = x_load ? x_in : x_reg_q;
    end

    // ------------------------------------------------------------------
    // Sub-counter: modulo up-count (single wrap) or saturating down-count
    // ------------------------------------------------------------------
    always_comb begin
        s_base   = s_zero ? S_LOAD_W : s_q;
        s_step_w = {{(SW-1){1'b0}}, s_step};
        s_sum    = {1'b0, s_base} + s_step_w;
        s_d      = s_q;
        if (s_en) begin
            if (s_add) begin
                if (s_sum >= S_MOD_W) begin
                    s_d = SW'(s_sum - S_MOD_W);
                end else begin
                    s_d = s_sum[SW-1:0];
                end
            end else begin
                if ({1'b0, s_base} < s_step_w) begin
                    s_d = '0;
                end else begin
                    s_d = s_base - SW'(s_step);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Main counter and sticky wrap flag
    // ------------------------------------------------------------------
    always_comb begin
        y_d     = y_q;
        y_ovf_d = y_ovf_q;
        if (y_en) begin
            if (y_store_x) begin
                y_d     = x_eff;
                y_ovf_d = 1'b0;
            end else begin
                case (y_select_next)
                    Y_SEL_HOLD: y_d = y_q;
                    Y_SEL_INC: begin
                        y_d = y_q + 1'b1;
                        if (y_q == Y_ONES) y_ovf_d = 1'b1;
                    end
                    Y_SEL_DEC: begin
                        y_d = y_q - 1'b1;
                        if (y_q == '0) y_ovf_d = 1'b1;
                    end
                    Y_SEL_CLR: y_d = '0;
                    default:   y_d = y_q;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs; flags come straight from the registered s.
    // ------------------------------------------------------------------
    assign y       = y_q;
    assign s       = s_q;
    assign y_ovf   = y_ovf_q;
    assign y_inc   = (s_q == S_LAST);
    assign s_empty = (s_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_count_data_path.sv
`default_nettype none
// ============================================================================
// Module   : tb_count_data_path
// Purpose  : Directed self-checking bench for count_data_path (default params)
// Revision : 1.0 - initial release
// ============================================================================
module tb_count_data_path;

    logic       clk;
    logic       rst;
    logic [7:0] x_in;
    logic       x_load;
    logic [1:0] y_select_next;
    logic [1:0] s_step;
    logic       y_en;
    logic       s_en;
    logic       y_store_x;
    logic       s_add;
    logic       s_zero;
    logic [7:0] y;
    logic [3:0] s;
    logic       y_inc;
    logic       s_empty;
    logic       y_ovf;

    int n_cmp;
    int n_bad;

    count_data_path #(.YW(8), .SW(4), .S_MOD(4), .S_LOAD(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .x_in          (x_in),
        .x_load        (x_load),
        .y_select_next (y_select_next),
        .s_step        (s_step),
        .y_en          (y_en),
        .s_en          (s_en),
        .y_store_x     (y_store_x),
        .s_add         (s_add),
        .s_zero        (s_zero),
        .y             (y),
        .s             (s),
        .y_inc         (y_inc),
        .s_empty       (s_empty),
        .y_ovf         (y_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        x_in = 8'h00; x_load = 1'b0; y_select_next = 2'd0; s_step = 2'd0;
        y_en = 1'b0; s_en = 1'b0; y_store_x = 1'b0; s_add = 1'b0; s_zero = 1'b0;
    endtask

    // One clock; outputs sampled 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Load y from a fresh preset through the bypass path.
    task automatic preset_y(input logic [7:0] v);
        idle();
        x_in = v; x_load = 1'b1; y_en = 1'b1; y_store_x = 1'b1;
        cyc();
        idle();
    endtask

    logic [3:0] exp_s_chain [8] = '{4'd1, 4'd2, 4'd3, 4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
    logic [7:0] exp_y_chain [8] = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd2};
    logic [3:0] exp_s_down  [5] = '{4'd6, 4'd4, 4'd2, 4'd0, 4'd0};

    initial begin
        n_cmp = 0;
        n_bad = 0;
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_y", y, 8'h00);
        chk("rst_s", s, 4'd0);
        chk("rst_s_empty", s_empty, 1'b1);
        chk("rst_y_inc", y_inc, 1'b0);
        chk("rst_y_ovf", y_ovf, 1'b0);

        // Reach y=0x35, s=2 in one cycle, then reset asynchronously.
        idle();
        x_in = 8'h35; x_load = 1'b1; y_en = 1'b1; y_store_x = 1'b1;
        s_en = 1'b1; s_add = 1'b1; s_step = 2'd2;
        cyc();
        chk("pre_rst_y", y, 8'h35);
        chk("pre_rst_s", s, 4'd2);
        chk("pre_rst_s_empty", s_empty, 1'b0);
        idle();
        #2 rst = 1'b1;
        #1;
        chk("async_rst_y", y, 8'h00);
        chk("async_rst_s", s, 4'd0);
        chk("async_rst_s_empty", s_empty, 1'b1);
        chk("async_rst_y_inc", y_inc, 1'b0);
        chk("async_rst_y_ovf", y_ovf, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Preset with bypass, then reuse captured x_reg.
        preset_y(8'h5A);
        chk("bypass_y", y, 8'h5A);
        chk("bypass_ovf", y_ovf, 1'b0);
        x_in = 8'h00; y_en = 1'b1; y_store_x = 1'b1;
        cyc();
        chk("xreg_y", y, 8'h5A);
        idle();
        y_en = 1'b1; y_select_next = 2'd3;
        cyc();
        chk("clr_y", y, 8'h00);

        // Count chain: y advances when the lookahead carry is seen.
        for (int i = 0; i < 8; i++) begin
            idle();
            s_en = 1'b1; s_add = 1'b1; s_step = 2'd1;
            y_en = y_inc; y_select_next = 2'd1;
            cyc();
            chk($sformatf("chain_s%0d", i), s, exp_s_chain[i]);
            chk($sformatf("chain_y%0d", i), y, exp_y_chain[i]);
        end
        chk("chain_y_inc_at0", y_inc, 1'b0);

        // Load base with step 0, then countdown with saturation.
        idle();
        s_en = 1'b1; s_zero = 1'b1; s_add = 1'b0; s_step = 2'd0;
        cyc();
        chk("sload_base", s, 4'd8);
        for (int i = 0; i < 5; i++) begin
            idle();
            s_en = 1'b1; s_zero = (i == 0); s_add = 1'b0; s_step = 2'd2;
            cyc();
            chk($sformatf("down_s%0d", i), s, exp_s_down[i]);
        end
        chk("down_s_empty", s_empty, 1'b1);

        // Up-count by 3 and wrap: 0+3=3 (carry lookahead), 3+3=6-4=2.
        idle();
        s_en = 1'b1; s_add = 1'b1; s_step = 2'd3;
        cyc();
        chk("add3_s", s, 4'd3);
        chk("add3_y_inc", y_inc, 1'b1);
        cyc();
        chk("wrap_s", s, 4'd2);
        chk("wrap_y_inc", y_inc, 1'b0);
        idle();

        // Overflow / underflow.
        preset_y(8'hFF);
        chk("ff_y", y, 8'hFF);
        y_en = 1'b1; y_select_next = 2'd1;
        cyc();
        chk("ovf_y", y, 8'h00);
        chk("ovf_flag", y_ovf, 1'b1);
        y_select_next = 2'd2;
        cyc();
        chk("unf_y", y, 8'hFF);
        chk("unf_flag_sticky", y_ovf, 1'b1);
        idle();
        x_in = 8'h10; x_load = 1'b1;
        cyc();
        chk("xload_only_y", y, 8'hFF);
        idle();
        y_en = 1'b1; y_store_x = 1'b1; y_select_next = 2'd1;
        cyc();
        chk("store_y", y, 8'h10);
        chk("store_clr_ovf", y_ovf, 1'b0);
        idle();
        y_en = 1'b1; y_select_next = 2'd3;
        cyc();
        chk("clr2_y", y, 8'h00);
        y_select_next = 2'd2;
        cyc();
        chk("dec0_y", y, 8'hFF);
        chk("dec0_ovf", y_ovf, 1'b1);

        // Enables off: nothing may move.
        for (int i = 0; i < 5; i++) begin
            idle();
            y_select_next = 2'(i); s_step = 2'(i + 1); s_add = i[0];
            s_zero = i[1]; y_store_x = 1'b1;
            cyc();
        end
        chk("noen_y", y, 8'hFF);
        chk("noen_s", s, 4'd2);
        chk("noen_ovf", y_ovf, 1'b1);
        idle();
        y_en = 1'b1; y_select_next = 2'd3;
        cyc();
        chk("sel3_y", y, 8'h00);
        chk("sel3_ovf_kept", y_ovf, 1'b1);
        chk("sel3_s_kept", s, 4'd2);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/count_data_path.md
Name: count_data_path

Overview:
- Datapath stage directly downstream of the counter control FSM.
- Holds the sub-counter `s` and the main counter `y`, plus a capture register for the external preset value `x`.
- Executes the FSM's one-hot-ish command strobes every clock.
- Returns the status flags the FSM branches on: `y_inc` (lookahead carry), `s_empty`, `y_ovf`.

Parameters:
- YW, 8, width of `y` and `x`.
- SW, 4, width of `s`.
- S_MOD, 4, `s` up-count modulus; must be ≤ 2^SW.
- S_LOAD, 8, base value substituted for `s` when `s_zero`=1; must be < 2^SW.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- x_in  in  YW  external preset value
- x_load  in  1  capture `x_in` into `x_reg`
- y_select_next  in  2  `y` next-value select
- s_step  in  2  `s` increment/decrement amount (0..3)
- y_en  in  1  `y` register write enable
- s_en  in  1  `s` register write enable
- y_store_x  in  1  with `y_en`: load `y` from `x`
- s_add  in  1  1 = add `s_step`, 0 = subtract `s_step`
- s_zero  in  1  replace current `s` by S_LOAD as the arithmetic base
- y  out  YW  main counter value (registered)
- s  out  SW  sub-counter value (registered)
- y_inc  out  1  lookahead: `s` == S_MOD-1 (combinational from `s` register)
- s_empty  out  1  `s` == 0 (combinational from `s` register)
- y_ovf  out  1  sticky overflow/underflow flag (registered)

Behaviour:
- Reset (async, rst=1):
  - `y`=0, `s`=0, `x_reg`=0, `y_ovf`=0.
  - Hence `s_empty`=1 and `y_inc`=0 (for S_MOD>1).
  - Reset mid-operation discards any update in flight.
- `x_reg`: `x_reg` <= `x_in` when `x_load`=1, else hold.
- Effective `x`: `x_eff` = `x_load` ? `x_in` : `x_reg`. This bypass lets a same-cycle `x_load` + `y_store_x` load the new value.
- `s` update (only when `s_en`=1; otherwise hold):
  - base = `s_zero` ? S_LOAD : `s`.
  - `s_add`=1: sum = base + `s_step`, computed SW+1 bits wide. `s` <= (sum ≥ S_MOD) ? sum − S_MOD : sum. Single wrap only; base < S_MOD is guaranteed unless `s_zero`.
  - `s_add`=0: `s` <= (base < `s_step`) ? 0 : base − `s_step`. Saturating at 0, no wrap.
  - `s_step`=0 with `s_en`=1 writes base. This is how the FSM loads S_LOAD via `s_zero`.
- `y` update (only when `y_en`=1; otherwise hold):
  - `y_store_x`=1 has priority: `y` <= `x_eff`, `y_ovf` <= 0.
  - Otherwise by `y_select_next`:
    - 0: hold.
    - 1: `y`+1, modulo 2^YW; wrap from all-ones sets `y_ovf`.
    - 2: `y`−1, modulo 2^YW; wrap from 0 sets `y_ovf`.
    - 3: `y` <= 0; `y_ovf` unchanged.
- `y_ovf` sticky: cleared only by reset or by a `y_store_x` load.
- Simultaneous `s_en` and `y_en` in one cycle: both registers update independently. `y_inc` reflects the pre-update `s` (value before the clock edge). This lets the FSM issue "s+1 and y+1" together when `y_inc`=1.
- Latency: every command takes effect at the next rising clk edge. Flags are valid combinationally from the registered values; no extra pipeline stage.
- No internal FSM beyond the registers. Commands arriving without `s_en`/`y_en` are ignored.

Test Plan:
- Reset then idle: assert rst mid-count with `y`=0x35, `s`=2 → immediately `y`=0, `s`=0, `s_empty`=1, `y_inc`=0, `y_ovf`=0.
- Preset with bypass: `x_in`=0x5A, `x_load`=1, `y_en`=1, `y_store_x`=1 in the same cycle → next cycle `y`=0x5A, `x_reg`=0x5A, `y_ovf`=0.
- Count chain (S_MOD=4): from `s`=0, `y`=0, apply `s_en`=1, `s_add`=1, `s_step`=1 each cycle; also `y_en`=1, `y_select_next`=1 whenever `y_inc`=1 → `s` sequence 1,2,3,0,1…; `y` increments exactly on the 3→0 cycle; after 8 cycles `y`=2, `s`=0.
- Load and countdown: `s_en`=1, `s_zero`=1, `s_add`=0, `s_step`=2 → `s`=6. Then `s_zero`=0, `s_step`=2 repeated → 4, 2, 0, then stays 0 with `s_empty`=1 (saturation).
- Overflow/underflow: `y`=0xFF, `y_select_next`=1 → `y`=0x00, `y_ovf`=1; then `y_select_next`=2 → `y`=0xFF, `y_ovf` stays 1; then `y_store_x` with `x_reg`=0x10 → `y`=0x10, `y_ovf`=0.
- Enables off: all selects driven with `y_en`=`s_en`=0 for 5 cycles → `y` and `s` unchanged; `y_select_next`=3 with `y_en`=1 → `y`=0, `y_ovf` unchanged.
